// File: rtl/decrypt_stream.sv
// decrypt_stream: two-stage streaming decryptor for the 5x5 Polybius /
// additive-key cipher. Stage 1 subtracts the positional key code from the
// ciphertext byte; stage 2 maps the difference back through the inverse
// substitution table or passes it through as a special character.
// Both sides use valid/ready handshakes; throughput is one beat per cycle.
//
// Optional feature: define DECRYPT_LOSSY_FLAG_EN to add out_lossy and to
// render the "unrecoverable character" marker (difference 8'hA5) as '?'.

module decrypt_stream #(
  parameter int SEC_LEN = 9  // key length; the key ROM holds "PARASCHIV"
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_sof,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_letter
`ifdef DECRYPT_LOSSY_FLAG_EN
  ,
  output logic       out_lossy
`endif
);

  localparam int IDX_W = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;

  // Inverse substitution table, row-major; entry (row-1)*5 + (col-1).
  localparam logic [7:0] LETTERS [25] = '{
    "M", "A", "T", "E", "I",
    "B", "C", "D", "F", "G",
    "H", "K", "L", "N", "O",
    "P", "Q", "R", "S", "U",
    "V", "W", "X", "Y", "Z"
  };

  // Polybius codes of the key letters P A R A S C H I V.
  function automatic logic [7:0] key_code(input logic [IDX_W-1:0] k);
    case (int'(k))
      0:       key_code = 8'd41;
      1:       key_code = 8'd12;
      2:       key_code = 8'd43;
      3:       key_code = 8'd12;
      4:       key_code = 8'd44;
      5:       key_code = 8'd22;
      6:       key_code = 8'd31;
      7:       key_code = 8'd15;
      8:       key_code = 8'd51;
      default: key_code = 8'd0;
    endcase
  endfunction

  // Sequential state
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             s1_valid_q, s1_valid_d;
  logic [7:0]       s1_d_q, s1_d_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_letter_q, out_letter_d;
`ifdef DECRYPT_LOSSY_FLAG_EN
  logic             out_lossy_q, out_lossy_d;
`endif

  // Combinational helpers
  logic             advance;
  logic             accept;
  logic [IDX_W-1:0] k;
  logic [7:0]       row, col;
  logic [4:0]       tidx;
  logic [7:0]       dec_data;
  logic             dec_letter;
  logic             dec_lossy;

  // Classify the stage-1 difference: letter code, lossy marker or special.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    row        = s1_d_q / 8'd10;
    col        = s1_d_q % 8'd10;
    tidx       = 5'((row - 8'd1) * 8'd5 + (col - 8'd1));
    dec_data   = s1_d_q;
    dec_letter = 1'b0;
    dec_lossy  = 1'b0;
    if (row >= 8'd1 && row <= 8'd5 && col >= 8'd1 && col <= 8'd5) begin
      dec_data   = LETTERS[tidx];
      dec_letter = 1'b1;
    end
`ifdef DECRYPT_LOSSY_FLAG_EN
    else if (s1_d_q == 8'hA5) begin
      dec_data  = 8'h3F;
      dec_lossy = 1'b1;
    end
`endif
  end

  // Handshakes, key indexing and next state for both pipeline stages.
  always_comb begin
    advance  = !out_valid_q || out_ready;
    in_ready = !s1_valid_q || advance;
    accept   = in_valid && in_ready;
    k        = in_sof ? '0 : idx_q;

    idx_d        = idx_q;
    s1_valid_d   = s1_valid_q;
    s1_d_d       = s1_d_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_letter_d = out_letter_q;
`ifdef DECRYPT_LOSSY_FLAG_EN
    out_lossy_d  = out_lossy_q;
`endif

    // Running index only moves on an accepted beat.
    if (accept) begin
      idx_d = (k == IDX_W'(SEC_LEN - 1)) ? '0 : k + IDX_W'(1);
    end

    // Stage 1 refills on accept; otherwise it empties when stage 2 takes it.
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_d_d     = in_data - key_code(k);
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end

    // Stage 2 data only changes when it loads a valid beat, so it holds
    // stable under backpressure.
    if (advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d   = dec_data;
        out_letter_d = dec_letter;
`ifdef DECRYPT_LOSSY_FLAG_EN
        out_lossy_d  = dec_lossy;
`endif
      end
    end
  end

  // Pipeline registers with asynchronous clear; reset drops in-flight beats.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      idx_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_d_q       <= 8'h00;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      out_letter_q <= 1'b0;
`ifdef DECRYPT_LOSSY_FLAG_EN
      out_lossy_q  <= 1'b0;
`endif
    end else begin
      idx_q        <= idx_d;
      s1_valid_q   <= s1_valid_d;
      s1_d_q       <= s1_d_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_letter_q <= out_letter_d;
`ifdef DECRYPT_LOSSY_FLAG_EN
      out_lossy_q  <= out_lossy_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_letter = out_letter_q;
`ifdef DECRYPT_LOSSY_FLAG_EN
  assign out_lossy  = out_lossy_q;
`endif

  // dec_lossy only drives a register when the lossy flag is built in.
  logic unused_ok;
  assign unused_ok = dec_lossy;

endmodule

// File: tb/tb_decrypt_stream.sv
// Testbench for decrypt_stream: table-driven directed vectors, hand-written
// multi-cycle sequences (key wrap, mid-stream sof, backpressure, reset) and
// randomized traffic, all scored against a behavioural cipher model.

module tb_decrypt_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_sof = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_letter;
`ifdef DECRYPT_LOSSY_FLAG_EN
  logic       out_lossy;
`endif

  decrypt_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_letter(out_letter)
`ifdef DECRYPT_LOSSY_FLAG_EN
    ,
    .out_lossy (out_lossy)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [7:0] data;
    logic       letter;
    logic       lossy;
  } exp_t;

  int    key_tab [9] = '{41, 12, 43, 12, 44, 22, 31, 15, 51};
  string grid = "MATEIBCDFGHKLNOPQRSUVWXYZ";

  function automatic exp_t model_decode(input logic [7:0] c, input int kidx);
    exp_t e;
    int d, r, cc;
    d  = ((int'(c) - key_tab[kidx]) % 256 + 256) % 256;
    r  = d / 10;
    cc = d % 10;
    e.data = 8'(d);
    e.letter = 1'b0;
    e.lossy = 1'b0;
    if (r >= 1 && r <= 5 && cc >= 1 && cc <= 5) begin
      e.data = grid[(r - 1) * 5 + (cc - 1)];
      e.letter = 1'b1;
    end
`ifdef DECRYPT_LOSSY_FLAG_EN
    else if (d == 165) begin
      e.data = 8'h3F;
      e.lossy = 1'b1;
    end
`endif
    return e;
  endfunction

  // Scoreboard / monitor, sampled on the falling edge.
  exp_t       exp_q[$];
  logic [7:0] got_q[$];
  int         m_idx = 0;
  int         acc_cnt = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] held_data;
  logic       held_letter;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_idx = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_data", out_data, held_data);
        check("hold_letter", out_letter, held_letter);
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_data", out_data, e.data);
          check("sb_letter", out_letter, e.letter);
`ifdef DECRYPT_LOSSY_FLAG_EN
          check("sb_lossy", out_lossy, e.lossy);
`endif
        end
        got_q.push_back(out_data);
      end
      if (in_valid && in_ready) begin
        int kk;
        kk = in_sof ? 0 : m_idx;
        exp_q.push_back(model_decode(in_data, kk));
        m_idx = (kk + 1) % 9;
        acc_cnt++;
      end
      stall_prev  = out_valid && !out_ready;
      held_data   = out_data;
      held_letter = out_letter;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic put_beat(input logic [7:0] d, input logic s);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("put_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", (exp_q.size() == 0) && !out_valid, 1);
  endtask

  typedef struct {
    logic [7:0] din;
    logic       sof;
    logic [7:0] exp_data;
    logic       exp_letter;
    logic       exp_lossy;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat;
    logic got;

    vecs.push_back('{8'd72,  1'b1, "H",   1'b1, 1'b0});
    vecs.push_back('{8'd27,  1'b0, "I",   1'b1, 1'b0});
    vecs.push_back('{8'd89,  1'b0, ".",   1'b0, 1'b0});
    vecs.push_back('{8'h19,  1'b1, 8'hF0, 1'b0, 1'b0});
    vecs.push_back('{8'd52,  1'b1, "M",   1'b1, 1'b0});
    vecs.push_back('{8'd106, 1'b1, "A",   1'b0, 1'b0});
    vecs.push_back('{8'd5,   1'b1, 8'd220, 1'b0, 1'b0});
`ifdef DECRYPT_LOSSY_FLAG_EN
    vecs.push_back('{8'd206, 1'b1, 8'h3F, 1'b0, 1'b1});
`else
    vecs.push_back('{8'd206, 1'b1, 8'hA5, 1'b0, 1'b0});
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_letter", out_letter, 0);
`ifdef DECRYPT_LOSSY_FLAG_EN
    check("rst_out_lossy", out_lossy, 0);
`endif
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven single beats with latency measurement
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      put_beat(vecs[i].din, vecs[i].sof);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 10) begin
        @(negedge clk);
        lat++;
        got = out_valid;
      end
      check($sformatf("vec%0d_valid", i), got, 1);
      check($sformatf("vec%0d_latency", i), lat, 2);
      check($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
      check($sformatf("vec%0d_letter", i), out_letter, vecs[i].exp_letter);
`ifdef DECRYPT_LOSSY_FLAG_EN
      check($sformatf("vec%0d_lossy", i), out_lossy, vecs[i].exp_lossy);
`endif
      @(posedge clk); #1;
    end
    drain();

    // Key wrap: ten back-to-back "M" beats, sof on the first only
    got_q.delete();
    for (int i = 0; i < 10; i++) put_beat(8'(11 + key_tab[i % 9]), i == 0);
    drain();
    check("wrap_count", got_q.size(), 10);
    foreach (got_q[i]) check($sformatf("wrap_m%0d", i), got_q[i], "M");

    // sof mid-stream at index 4 restarts the key at P
    got_q.delete();
    put_beat(8'd52, 1'b1);
    put_beat(8'd23, 1'b0);
    put_beat(8'd54, 1'b0);
    put_beat(8'd23, 1'b0);
    put_beat(8'd72, 1'b1);
    drain();
    check("midsof_count", got_q.size(), 5);
    if (got_q.size() == 5) check("midsof_h", got_q[4], "H");

    // Backpressure: stalled consumer, producer always valid
    got_q.delete();
    acc_cnt = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_sof = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(60 + acc_cnt);
      @(posedge clk); #1;
      in_sof = 1'b0;
    end
    @(negedge clk);
    check("bp_accepted", acc_cnt, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    check("bp_out_count", got_q.size(), 2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_sof    = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    in_sof = 1'b0;
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    put_beat(8'd72, 1'b1);
    put_beat(8'd27, 1'b0);
    check("prerst_out_valid", out_valid, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_data", out_data, 8'h00);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    got_q.delete();
    out_ready = 1'b1;
    put_beat(8'd72, 1'b0);
    drain();
    check("postrst_count", got_q.size(), 1);
    if (got_q.size() == 1) check("postrst_h", got_q[0], "H");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/decrypt_stream.md
Name: decrypt_stream

Overview:
- Streaming decryptor for the 5x5 Polybius/additive-key cipher used by the encrypt block.
- Takes one ciphertext byte per accepted beat and subtracts the positional key code. It then maps the result back through the inverse substitution table, or passes it through as a special character.
- Sits on the receive side, downstream of the link that carries encrypt output, and feeds the plaintext consumer.
- Two-stage pipeline with valid/ready handshakes on both sides.

Parameters:
- SEC_LEN, 9, key length. Key ROM contents are fixed as "PARASCHIV".
- Key codes are fixed: P=41, A=12, R=43, A=12, S=44, C=22, H=31, I=15, V=51.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ciphertext beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  8  ciphertext byte.
- in_sof  in  1  start of message, sampled with the beat. Forces key index 0 for this beat.
- out_valid  out  1  plaintext beat valid.
- out_ready  in  1  consumer accepts.
- out_data  out  8  recovered byte.
- out_letter  out  1  1 = byte decoded via the table, 0 = pass-through special.

Behaviour:
- Reset: in_ready=1, out_valid=0, out_data=8'h00, out_letter=0, key index=0, both stage valids cleared. Reset mid-message drops all in-flight beats, and the next beat uses key index 0.
- Substitution table, row-major, rows/cols 1..5: M A T E I / B C D F G / H K L N O / P Q R S U / V W X Y Z. Code = row*10+col.
- Input beat accepted when in_valid && in_ready.
- Key index k:
  - k = 0 if in_sof, else the running index.
  - After acceptance, running index = (k+1) mod SEC_LEN, wrapping from SEC_LEN-1 to 0.
  - Index does not advance on non-accepted cycles.
- Stage 1 (on accept): d = (in_data - keycode[k]) mod 256, 8-bit wrap. Register d and s1_valid.
- Stage 2 classification:
  - If d is in {11..15, 21..25, 31..35, 41..45, 51..55}: out_data = table[d/10][d%10], out_letter=1.
  - Otherwise: out_data = d, out_letter=0.
  - Letter decode always takes priority. Special characters whose ASCII value lies in the code set decode as letters; this is an accepted cipher limitation.
- Latency: 2 cycles from accept to out_valid when there is no backpressure.
- Throughput: 1 beat/cycle.
- Stage advance rules:
  - s2 loads when (!out_valid || out_ready).
  - s1 moves to s2 on that same condition.
  - in_ready = !s1_valid || (!out_valid || out_ready), combinational.
- Backpressure:
  - While out_valid && !out_ready: out_data and out_letter hold stable, and at most one more beat is accepted into s1.
- Simultaneous output drain and input accept in the same cycle are both performed.
- in_sof on a non-accepted cycle is ignored.
- Byte order is strictly preserved; no beat is dropped or duplicated.

Optional Feature:
- Macro: DECRYPT_LOSSY_FLAG_EN.
- Background: the encryptor maps lowercase letters and 'J' to code 165, so d = 8'hA5 marks an unrecoverable character.
- With the macro:
  - Adds output port out_lossy (1 bit, reset 0).
  - When d == 8'hA5: out_data = "?" (8'h3F), out_letter=0, out_lossy=1.
  - out_lossy is 0 for every other beat and holds with out_data under backpressure.
- Without the macro: no port is added, and d = 8'hA5 passes through as 8'hA5 with out_letter=0.

Test Plan:
- Basic decode: in_sof=1 with 72, then 27, out_ready=1. Required: out_data "H" then "I", out_letter=1 for both, first out_valid 2 cycles after the first accept.
- Special pass-through and 8-bit wrap: beats 72, 27, 89 (index 2, key R=43). Required: third output "." (46), out_letter=0. A beat at index 0 with in_data 8'h19 (from 0xF0+41) must return 8'hF0, out_letter=0.
- Key wrap and sof:
  - Stream 10 beats, each encoding "M" (11+key), in_sof on the first only. Required: all outputs "M"; the 10th beat uses key index 0 (in_data 52).
  - Then in_sof mid-stream at index 4. Required: that beat decodes with P=41.
- Backpressure: hold out_ready=0 for 5 cycles while in_valid=1. Required:
  - in_ready drops after 2 accepted beats.
  - out_data stable throughout.
  - After release, all beats emerge in order with no loss or duplication.
- Lossy handling: index 0, in_data 206. Required: 8'h3F with out_lossy=1 when DECRYPT_LOSSY_FLAG_EN is defined, otherwise 8'hA5 with out_letter=0.
- Reset mid-stream: assert rst_n=0 asynchronously with 2 beats in flight. Required:
  - out_valid=0 immediately.
  - After release, a beat of 72 without in_sof decodes as "H" (key index 0).
